// File: rtl/if_pkg.sv
// if_pkg: shared constants and FSM encoding for the instruction fetch stage
package if_pkg;
  localparam int IF_INST_W = 32;
  localparam logic [31:0] IF_RESET_PC = 32'h0;
  localparam logic [IF_INST_W-1:0] IF_NOP = 32'h0;
  localparam int IF_PC_INC = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DROP = 2'd2} if_state_e;
endpackage

// File: rtl/if_skid_buf.sv
// if_skid_buf: 1-entry {inst,pc} buffer; ports clk, rst_n, push/pop/flush, push_inst/push_pc in, full, head_inst/head_pc out
module if_skid_buf
  import if_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = IF_INST_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [INST_W-1:0] push_inst,
  input  logic [ADDR_W-1:0] push_pc,
  output logic              full,
  output logic [INST_W-1:0] head_inst,
  output logic [ADDR_W-1:0] head_pc
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      head_inst <= IF_NOP;
      head_pc <= '0;
    end else begin
      full <= !flush && (push || (full && !pop));
      if (push) begin
        head_inst <= push_inst;
        head_pc <= push_pc;
      end
    end
  end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: owns the PC, fetches words over req/ready/rvalid and presents {inst,pc} to IF/DE
// ports: clk, rst_n, stall, redirect, redirect_pc in; imem_req, imem_addr out; imem_ready,
// imem_rvalid, imem_rdata in; inst_out, inst_valid, pc_out out
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = IF_INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IF_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] inst_out,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] pc_out
);
  if_state_e state, state_nx;
  logic [ADDR_W-1:0] pc, rsp_pc, skid_pc;
  logic [INST_W-1:0] skid_inst;
  logic [1:0] occ;
  logic skid_full, consume, out_free, rsp, accept, push, pop, load_out;

  assign consume = inst_valid && !stall;
  assign out_free = !inst_valid || !stall;
  assign occ = 2'(inst_valid) + 2'(skid_full) + 2'(state != IDLE) - 2'(consume);
  // a new request may only overlap the cycle in which the outstanding one returns
  assign imem_req = rst_n && !redirect && occ < 2'd2 && (state == IDLE || (state == WAIT && imem_rvalid));
  assign imem_addr = pc;
  assign accept = imem_req && imem_ready;
  assign rsp = state == WAIT && imem_rvalid && !redirect;
  // pc already advanced past the single outstanding request
  assign rsp_pc = pc - ADDR_W'(IF_PC_INC);
  assign load_out = !redirect && out_free && (skid_full || rsp);
  assign pop = out_free && skid_full;
  assign push = rsp && (skid_full || !out_free);

  if_skid_buf #(.ADDR_W(ADDR_W), .INST_W(INST_W)) u_skid (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .flush(redirect),
    .push_inst(imem_rdata),
    .push_pc(rsp_pc),
    .full(skid_full),
    .head_inst(skid_inst),
    .head_pc(skid_pc)
  );

  always_comb begin
    state_nx = state;
    if (redirect) state_nx = (state != IDLE && !imem_rvalid) ? DROP : IDLE;
    else if (state == IDLE || imem_rvalid) state_nx = accept ? WAIT : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      inst_out <= IF_NOP;
      pc_out <= '0;
      inst_valid <= 1'b0;
    end else begin
      state <= state_nx;
      pc <= redirect ? {redirect_pc[ADDR_W-1:2], 2'b00} : accept ? pc + ADDR_W'(IF_PC_INC) : pc;
      inst_valid <= load_out || (!redirect && inst_valid && stall);
      if (load_out) begin
        inst_out <= skid_full ? skid_inst : imem_rdata;
        pc_out <= skid_full ? skid_pc : rsp_pc;
      end
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed bench for if_fetch_unit with a fixed-latency memory responder
module tb_if_fetch_unit;
  logic clk = 1'b0;
  logic rst_n, stall, redirect, imem_req, imem_ready, imem_rvalid, inst_valid;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, inst_out, pc_out;
  int n_tests = 0;
  int n_fail = 0;
  int k = 1;
  logic hold = 1'b1;
  logic acc, v1 = 1'b0, v2 = 1'b0;
  logic [31:0] acc_a, a1 = '0, a2 = '0;

  if_fetch_unit dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .inst_out(inst_out),
    .inst_valid(inst_valid),
    .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  initial begin
    imem_rvalid = 1'b0;
    imem_rdata = '0;
  end

  // memory: a request accepted at an edge answers k cycles later, one response per request
  always begin
    @(negedge clk);
    acc = imem_req && imem_ready && !hold;
    acc_a = imem_addr;
    @(posedge clk);
    #1;
    if (k == 1) begin
      v1 = acc;
      a1 = acc_a;
    end else begin
      v1 = v2;
      a1 = a2;
      v2 = acc;
      a2 = acc_a;
    end
    imem_rvalid = v1;
    imem_rdata = v1 ? mem_word(a1) : 32'h0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (inst_valid) break;
    end
    check({tag, "_timeout"}, 32'(inst_valid), 32'h1);
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    imem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("rst_req", 32'(imem_req), 32'h1);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(inst_valid), 32'h0);
    check("rst_inst", inst_out, 32'h0);
    check("rst_pc_out", pc_out, 32'h0);
    tick();
    #1;
    check("wait_req", 32'(imem_req), 32'h0);
    check("wait_addr", imem_addr, 32'h4);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(inst_valid), 32'h0);
    check("mid_rst_req", 32'(imem_req), 32'h0);
    check("mid_rst_inst", inst_out, 32'h0);
    check("mid_rst_addr", imem_addr, 32'h0);
    hold = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("c1_valid", 32'(inst_valid), 32'h0);
    #1;
    check("c1_req", 32'(imem_req), 32'h1);
    check("c1_addr", imem_addr, 32'h4);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stream_valid", 32'(inst_valid), 32'h1);
      check("stream_pc", pc_out, 32'(4 * i));
      check("stream_inst", inst_out, 32'hC0DE_0000 + 32'(4 * i));
    end
    stall = 1'b1;
    #1;
    check("stall_occ2_req", 32'(imem_req), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", pc_out, 32'h8);
      check("stall_inst", inst_out, 32'hC0DE_0008);
      check("stall_valid", 32'(inst_valid), 32'h1);
      #1;
      check("stall_req", 32'(imem_req), 32'h0);
    end
    stall = 1'b0;
    #1;
    check("unstall_req", 32'(imem_req), 32'h1);
    check("unstall_addr", imem_addr, 32'h10);
    tick();
    check("skid_pc", pc_out, 32'hC);
    check("skid_inst", inst_out, 32'hC0DE_000C);
    tick();
    check("after_skid_pc", pc_out, 32'h10);
    check("after_skid_inst", inst_out, 32'hC0DE_0010);
    imem_ready = 1'b0;
    #1;
    check("nordy_req", 32'(imem_req), 32'h1);
    check("nordy_addr", imem_addr, 32'h18);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("nordy_valid", 32'(inst_valid), (i == 0) ? 32'h1 : 32'h0);
      #1;
      check("nordy_req", 32'(imem_req), 32'h1);
      check("nordy_addr", imem_addr, 32'h18);
    end
    check("nordy_last_pc", pc_out, 32'h14);
    imem_ready = 1'b1;
    k = 2;
    wait_valid("k2_first");
    check("k2_pc0", pc_out, 32'h18);
    wait_valid("k2_second");
    check("k2_pc1", pc_out, 32'h1C);
    redirect = 1'b1;
    redirect_pc = 32'h102;
    #1;
    check("redir_req", 32'(imem_req), 32'h0);
    tick();
    redirect = 1'b0;
    check("redir_valid", 32'(inst_valid), 32'h0);
    wait_valid("redir_first");
    check("redir_pc0", pc_out, 32'h100);
    check("redir_inst0", inst_out, 32'hC0DE_0100);
    wait_valid("redir_second");
    check("redir_pc1", pc_out, 32'h104);
    stall = 1'b1;
    repeat (4) tick();
    check("full_valid", 32'(inst_valid), 32'h1);
    check("full_pc", pc_out, 32'h104);
    check("full_inst", inst_out, 32'hC0DE_0104);
    #1;
    check("full_req", 32'(imem_req), 32'h0);
    redirect = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    stall = 1'b0;
    check("rs_valid", 32'(inst_valid), 32'h0);
    #1;
    check("rs_req", 32'(imem_req), 32'h1);
    check("rs_addr", imem_addr, 32'h200);
    wait_valid("rs_first");
    check("rs_pc", pc_out, 32'h200);
    check("rs_inst", inst_out, 32'hC0DE_0200);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
